mixer_accum_sequencer: RTL and testbench
========================================

Name: mixer_accum_sequencer

Overview:
- Controls one complex multiply-accumulate mixer. The mixer is a 3-DSP pipeline with a synchronous-load accumulator, fixed operand-to-output latency and an sload-to-clear offset.
- Gates incoming sample/LO operand pairs, issues the mixer sload at each window start, and captures the accumulated complex sum after the last sample of a window has drained.
- Sits between the sample/LO stream and the downstream result consumer (readout/FIFO).

Parameters:
- AWIDTH, 16, sample operand width (ar/ai).
- BWIDTH, 18, LO operand width (br/bi).
- SIZEOUT, 40, accumulator/result width.
- LEN_WIDTH, 16, width of window-length configuration.
- MIX_LATENCY, 6, cycles from operands on mixer inputs to their contribution visible on mixer pr/pi.
- SLOAD_OFFSET, 4, cycles from a window's first operands on mixer inputs to the mixer sload assertion.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_len  in  LEN_WIDTH  samples per window, latched at window start
- cfg_continuous  in  1  1 = windows back-to-back until stop; 0 = single window
- start  in  1  one-cycle pulse; begins operation when idle
- stop  in  1  one-cycle pulse; ends operation at the current window boundary
- busy  out  1  high from start until the last result is captured
- s_valid  in  1  sample/LO pair valid this cycle
- s_ar, s_ai  in  AWIDTH each  sample real/imag
- s_br, s_bi  in  BWIDTH each  LO real/imag
- mix_ar, mix_ai  out  AWIDTH each  operands to mixer
- mix_br, mix_bi  out  BWIDTH each  operands to mixer
- mix_sload  out  1  mixer synchronous load
- mix_pr, mix_pi  in  SIZEOUT each  mixer outputs
- res_valid  out  1  result held
- res_ready  in  1  consumer accepts result
- res_re, res_im  out  SIZEOUT each  captured window sum
- overrun  out  1  sticky: a result was dropped
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the following:
  - state=IDLE, busy=0, mix_sload=0, mix_* operands=0;
  - res_valid=0, res_re=res_im=0, overrun=0;
  - all delay lines, counters and stop_pending.
- Reset mid-window abandons the window; no result is produced.
- Operand gating:
  - mix_* are registered, 1 cycle after s_*.
  - When s_valid=0 or state≠RUN, operands are zero, so the cycle contributes 0 to the accumulator.
- States:
  - IDLE: start → RUN and busy=1. Latch cfg_len; cfg_len=0 is treated as 1. Sample counter=0.
  - RUN: each s_valid increments the counter.
    - The first valid sample of a window raises a start tag.
    - The sample that makes counter==len raises an end tag. Counter resets and len is relatched from cfg_len.
    - At that boundary: if cfg_continuous=0 or stop_pending=1, go to DRAIN and accept no further samples. Otherwise stay in RUN.
  - DRAIN: wait until the end-tag delay line is empty, then → IDLE and busy=0.
- stop: sets stop_pending in RUN; cleared on entering IDLE. stop in IDLE is ignored. start while busy is ignored.
- Tag timing, with t = cycle the operands appear on mix_*:
  - start tag → mix_sload=1 exactly in cycle t+SLOAD_OFFSET, for 1 cycle.
  - end tag → capture mix_pr/mix_pi in cycle t+MIX_LATENCY.
  - With the defaults, capture precedes the next window's clear even when windows are back-to-back.
- Output buffer: single entry.
  - Capture with res_valid=0, or with res_valid=1 and res_ready=1 in the same cycle → load, res_valid=1.
  - Capture with res_valid=1 and res_ready=0 → drop the new result, overrun=1.
  - res_valid && res_ready without capture → res_valid=0.
- overrun_clr clears overrun; a set event in the same cycle wins.
- Single-sample windows (len=1): start and end tags on the same sample; both delay lines operate independently.
- Result arithmetic is the mixer's: re=Σ(ar·br−ai·bi), im=Σ(ar·bi+ai·br), wrapping at SIZEOUT.

Decomposition:
- Package mixer_seq_pkg holds:
  - default latency constants (MIX_LATENCY, SLOAD_OFFSET);
  - the state enum (IDLE, RUN, DRAIN);
  - an assertion-check constant requiring SLOAD_OFFSET < MIX_LATENCY.
- Sub-module mixer_tag_delay: a parameterised single-bit shift register with reset and an any-bit-set output. Instantiate twice: start tag with depth SLOAD_OFFSET, end tag with depth MIX_LATENCY.

Test Plan:
1. len=4, continuous, s_valid every cycle, ar=1000 ai=0 br=2 bi=0 → results re=8000 im=0 every 4 cycles; mix_sload period 4; no overrun with res_ready=1.
2. len=2, single, ar=3 ai=4 br=1 bi=2 → one result re=−10 im=20; busy falls after capture; later samples ignored.
3. len=3, s_valid 1,0,0,1,0,1 (ar=1 br=1, others 0) → re=3 im=0; gap cycles add nothing.
4. len=1, continuous, ar=k (k=1..5) br=1 → results 1,2,3,4,5 in order, one per cycle.
5. res_ready=0, len=2, continuous, ar=br=1 → first result (2) held, overrun=1 at second capture; overrun_clr → 0.
6. stop mid-window (sample 2 of len=4), then rst_n low mid-window in a second run → first run completes its window then IDLE; reset run yields no result, all outputs 0.

Source files
------------

// File: rtl/mixer_seq_pkg.sv
// Shared constants for the mixer accumulate sequencer: default mixer timing,
// FSM state encodings and the sload-before-capture ordering check.
package mixer_seq_pkg;

  localparam int MIX_LATENCY_DEF  = 6;
  localparam int SLOAD_OFFSET_DEF = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  function automatic bit offsets_ordered(input int sload_offset, input int mix_latency);
    return sload_offset < mix_latency;
  endfunction

  // The clear of a window must land before that window's sum is read out.
  localparam bit SLOAD_BEFORE_CAPTURE = offsets_ordered(SLOAD_OFFSET_DEF, MIX_LATENCY_DEF);

endpackage

// File: rtl/mixer_tag_delay.sv
// Single-bit tag shift register; dout is the tag DEPTH cycles later and any
// reports whether a tag is still in flight.
module mixer_tag_delay
  import mixer_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic any
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= (sr << 1) | DEPTH'(din);
    end
  end

  assign dout = sr[DEPTH-1];
  assign any  = |sr;

endmodule

// File: rtl/mixer_accum_sequencer.sv
// Sequencer for a complex multiply-accumulate mixer: gates sample/LO operands,
// pulses sload at each window start and captures the window sum once drained.
module mixer_accum_sequencer
  import mixer_seq_pkg::*;
#(
  parameter int AWIDTH       = 16,
  parameter int BWIDTH       = 18,
  parameter int SIZEOUT      = 40,
  parameter int LEN_WIDTH    = 16,
  parameter int MIX_LATENCY  = MIX_LATENCY_DEF,
  parameter int SLOAD_OFFSET = SLOAD_OFFSET_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 cfg_continuous,
  input  logic                 start,
  input  logic                 stop,
  output logic                 busy,
  input  logic                 s_valid,
  input  logic [AWIDTH-1:0]    s_ar,
  input  logic [AWIDTH-1:0]    s_ai,
  input  logic [BWIDTH-1:0]    s_br,
  input  logic [BWIDTH-1:0]    s_bi,
  output logic [AWIDTH-1:0]    mix_ar,
  output logic [AWIDTH-1:0]    mix_ai,
  output logic [BWIDTH-1:0]    mix_br,
  output logic [BWIDTH-1:0]    mix_bi,
  output logic                 mix_sload,
  input  logic [SIZEOUT-1:0]   mix_pr,
  input  logic [SIZEOUT-1:0]   mix_pi,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [SIZEOUT-1:0]   res_re,
  output logic [SIZEOUT-1:0]   res_im,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  if (!(SLOAD_BEFORE_CAPTURE && offsets_ordered(SLOAD_OFFSET, MIX_LATENCY))) begin : g_bad_offsets
    $error("SLOAD_OFFSET must be smaller than MIX_LATENCY");
  end

  function automatic logic [LEN_WIDTH-1:0] norm_len(input logic [LEN_WIDTH-1:0] len);
    return (len == '0) ? LEN_WIDTH'(1) : len;
  endfunction

  logic [1:0]                state;
  logic [LEN_WIDTH-1:0]      cnt;
  logic [LEN_WIDTH-1:0]      len_q;
  logic                      stop_pending;
  logic                      accept;
  logic                      first_smp;
  logic                      last_smp;
  logic signed [AWIDTH-1:0]  ar_p1;
  logic signed [AWIDTH-1:0]  ai_p1;
  logic signed [BWIDTH-1:0]  br_p1;
  logic signed [BWIDTH-1:0]  bi_p1;
  logic                      stag_p1;
  logic                      etag_p1;
  logic                      start_any;
  logic                      end_any;
  logic                      capture;
  logic                      drain_done;

  assign accept    = s_valid && (state == RUN);
  assign first_smp = accept && (cnt == '0);
  assign last_smp  = accept && (cnt == len_q - LEN_WIDTH'(1));

  // Stage p1: operands and window tags registered onto the mixer inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ar_p1   <= '0;
      ai_p1   <= '0;
      br_p1   <= '0;
      bi_p1   <= '0;
      stag_p1 <= 1'b0;
      etag_p1 <= 1'b0;
    end else begin
      ar_p1   <= accept ? s_ar : '0;
      ai_p1   <= accept ? s_ai : '0;
      br_p1   <= accept ? s_br : '0;
      bi_p1   <= accept ? s_bi : '0;
      stag_p1 <= first_smp;
      etag_p1 <= last_smp;
    end
  end

  assign mix_ar = ar_p1;
  assign mix_ai = ai_p1;
  assign mix_br = br_p1;
  assign mix_bi = bi_p1;

  mixer_tag_delay #(.DEPTH(SLOAD_OFFSET)) u_start_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (stag_p1),
    .dout (mix_sload),
    .any  (start_any)
  );

  mixer_tag_delay #(.DEPTH(MIX_LATENCY)) u_end_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (etag_p1),
    .dout (capture),
    .any  (end_any)
  );

  assign drain_done = !(stag_p1 || start_any || etag_p1 || end_any);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      len_q        <= '0;
      stop_pending <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_pending <= 1'b0;
          if (start) begin
            state <= RUN;
            len_q <= norm_len(cfg_len);
            cnt   <= '0;
          end
        end
        RUN: begin
          if (stop) stop_pending <= 1'b1;
          if (last_smp) begin
            cnt   <= '0;
            len_q <= norm_len(cfg_len);
            if (!cfg_continuous || stop_pending) state <= DRAIN;
          end else if (accept) begin
            cnt <= cnt + LEN_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Single-entry result buffer; a capture into an unconsumed entry is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_re    <= '0;
      res_im    <= '0;
      overrun   <= 1'b0;
    end else begin
      if (capture && (!res_valid || res_ready)) begin
        res_valid <= 1'b1;
        res_re    <= mix_pr;
        res_im    <= mix_pi;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (capture && res_valid && !res_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mixer_accum_sequencer.sv
// Scoreboard bench for mixer_accum_sequencer with a behavioural mixer model and
// window sums computed directly from the accepted sample stream.
module tb_mixer_accum_sequencer;
  import mixer_seq_pkg::*;

  localparam int AW = 16;
  localparam int BW = 18;
  localparam int OW = 40;
  localparam int LW = 16;
  localparam int ML = MIX_LATENCY_DEF;
  localparam int SO = SLOAD_OFFSET_DEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [LW-1:0] cfg_len;
  logic          cfg_continuous;
  logic          start, stop;
  logic          busy;
  logic          s_valid;
  logic [AW-1:0] s_ar, s_ai;
  logic [BW-1:0] s_br, s_bi;
  logic [AW-1:0] mix_ar, mix_ai;
  logic [BW-1:0] mix_br, mix_bi;
  logic          mix_sload;
  logic [OW-1:0] mix_pr = '0, mix_pi = '0;
  logic          res_valid, res_ready;
  logic [OW-1:0] res_re, res_im;
  logic          overrun, overrun_clr;

  mixer_accum_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_continuous(cfg_continuous),
    .start(start), .stop(stop), .busy(busy), .s_valid(s_valid),
    .s_ar(s_ar), .s_ai(s_ai), .s_br(s_br), .s_bi(s_bi),
    .mix_ar(mix_ar), .mix_ai(mix_ai), .mix_br(mix_br), .mix_bi(mix_bi),
    .mix_sload(mix_sload), .mix_pr(mix_pr), .mix_pi(mix_pi),
    .res_valid(res_valid), .res_ready(res_ready), .res_re(res_re), .res_im(res_im),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  typedef struct { bit v; int ar; int ai; int br; int bi; } samp_t;
  typedef struct { logic [OW-1:0] re; logic [OW-1:0] im; } res_t;

  samp_t  stim[$];
  res_t   exp_q[$];
  int     sload_q[$];
  int     hs_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     first_op = -1;
  longint pq_re[$], pq_im[$];
  longint acc_re = 0, acc_im = 0;

  // Mixer model: product reaches the accumulator SO cycles after the operands,
  // sload loads instead of adding, the sum shows on pr/pi ML cycles after.
  initial for (int i = 0; i < SO; i++) begin pq_re.push_back(0); pq_im.push_back(0); end

  always @(posedge clk) begin
    longint pre, pim, ore, oim;
    cyc++;
    pre = longint'($signed(mix_ar)) * longint'($signed(mix_br))
        - longint'($signed(mix_ai)) * longint'($signed(mix_bi));
    pim = longint'($signed(mix_ar)) * longint'($signed(mix_bi))
        + longint'($signed(mix_ai)) * longint'($signed(mix_br));
    pq_re.push_back(pre); pq_im.push_back(pim);
    ore = pq_re.pop_front(); oim = pq_im.pop_front();
    mix_pr <= acc_re[OW-1:0];
    mix_pi <= acc_im[OW-1:0];
    if (mix_sload) begin acc_re = ore; acc_im = oim; end
    else begin acc_re = acc_re + ore; acc_im = acc_im + oim; end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    res_t e;
    if (mix_sload) sload_q.push_back(cyc);
    if (first_op < 0 && mix_ar != '0) first_op = cyc;
    if (rst_n && res_valid && res_ready) begin
      hs_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result actual=%0h/%0h required=none", res_re, res_im);
      end else begin
        e = exp_q.pop_front();
        chk("res_re", res_re, e.re);
        chk("res_im", res_im, e.im);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input samp_t s, input bit stp);
    s_valid = s.v;
    s_ar = AW'(s.ar); s_ai = AW'(s.ai);
    s_br = BW'(s.br); s_bi = BW'(s.bi);
    stop = stp;
    step();
    stop = 1'b0;
  endtask

  // Expected sums: the first nwin*len valid samples grouped into windows of len.
  task automatic play(input int len, input int cfgl, input int nwin,
                      input bit use_stop, input bit push_exp);
    int vc; bit stopped; longint sr, si; samp_t idle_s; res_t r;
    vc = 0; sr = 0; si = 0; stopped = 0;
    idle_s.v = 0; idle_s.ar = 0; idle_s.ai = 0; idle_s.br = 0; idle_s.bi = 0;
    if (push_exp) foreach (stim[i]) if (stim[i].v && vc < nwin * len) begin
      sr += longint'(stim[i].ar) * stim[i].br - longint'(stim[i].ai) * stim[i].bi;
      si += longint'(stim[i].ar) * stim[i].bi + longint'(stim[i].ai) * stim[i].br;
      vc++;
      if (vc % len == 0) begin
        r.re = sr[OW-1:0]; r.im = si[OW-1:0];
        exp_q.push_back(r);
        sr = 0; si = 0;
      end
    end
    vc = 0;
    cfg_len = LW'(cfgl);
    cfg_continuous = use_stop || (nwin > 1);
    start = 1'b1; step(); start = 1'b0;
    foreach (stim[i]) begin
      if (use_stop && !stopped && vc == (nwin - 1) * len) begin
        drive(idle_s, 1'b1);
        stopped = 1;
      end
      if (!use_stop) cfg_continuous = (vc < (nwin - 1) * len);
      drive(stim[i], 1'b0);
      if (stim[i].v) vc++;
    end
    drive(idle_s, 1'b0);
  endtask

  task automatic finish_run(input string name);
    int n;
    n = 0;
    while (busy && n < 300) begin step(); n++; end
    chk({name, "_idle"}, busy, 0);
    step(); step();
    chk({name, "_sb_empty"}, exp_q.size(), 0);
  endtask

  function automatic samp_t mk(input bit v, input int ar, input int ai, input int br, input int bi);
    samp_t s;
    s.v = v; s.ar = ar; s.ai = ai; s.br = br; s.bi = bi;
    return s;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t  r;
    int    len, nwin, vc;
    bit    vv;
    rst_n = 1'b0; cfg_len = '0; cfg_continuous = 1'b0; start = 1'b0; stop = 1'b0;
    s_valid = 1'b0; s_ar = '0; s_ai = '0; s_br = '0; s_bi = '0;
    res_ready = 1'b1; overrun_clr = 1'b0;
    step(); step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_re", res_re, 0);
    chk("rst_res_im", res_im, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sload", mix_sload, 0);
    chk("rst_mix_ar", mix_ar, 0);
    chk("rst_mix_bi", mix_bi, 0);
    rst_n = 1'b1; step();

    // continuous len=4 windows of constant operands
    stim.delete();
    for (int i = 0; i < 12; i++) stim.push_back(mk(1, 1000, 0, 2, 0));
    sload_q.delete(); first_op = -1;
    play(4, 4, 3, 0, 1);
    finish_run("t1");
    chk("t1_sload_count", sload_q.size(), 3);
    chk("t1_sload_period_a", sload_q[1] - sload_q[0], 4);
    chk("t1_sload_period_b", sload_q[2] - sload_q[1], 4);
    chk("t1_sload_offset", sload_q[0] - first_op, SO);
    chk("t1_overrun", overrun, 0);

    // single window; samples after the window must not be accepted
    stim.delete();
    for (int i = 0; i < 5; i++) stim.push_back(mk(1, 3, 4, 1, 2));
    play(2, 2, 1, 0, 1);
    chk("t2_busy_before_capture", busy, 1);
    chk("t2_result_pending", exp_q.size(), 1);
    finish_run("t2");

    // gaps in s_valid contribute nothing
    stim.delete();
    foreach (stim[i]) stim.delete(i);
    stim.push_back(mk(1, 1, 0, 1, 0)); stim.push_back(mk(0, 9, 9, 9, 9));
    stim.push_back(mk(0, 7, 7, 7, 7)); stim.push_back(mk(1, 1, 0, 1, 0));
    stim.push_back(mk(0, 5, 5, 5, 5)); stim.push_back(mk(1, 1, 0, 1, 0));
    play(3, 3, 1, 0, 1);
    finish_run("t3");

    // single-sample windows back-to-back
    stim.delete();
    for (int k = 1; k <= 5; k++) stim.push_back(mk(1, k, 0, 1, 0));
    hs_q.delete();
    play(1, 1, 5, 0, 1);
    finish_run("t4");
    chk("t4_result_count", hs_q.size(), 5);
    chk("t4_one_per_cycle", hs_q[4] - hs_q[0], 4);

    // consumer stalled: second result dropped, overrun sticky until cleared
    res_ready = 1'b0;
    stim.delete();
    for (int i = 0; i < 4; i++) stim.push_back(mk(1, 1, 0, 1, 0));
    play(2, 2, 2, 0, 0);
    finish_run("t5");
    chk("t5_res_valid_held", res_valid, 1);
    chk("t5_res_re_held", res_re, 2);
    chk("t5_res_im_held", res_im, 0);
    chk("t5_overrun_set", overrun, 1);
    overrun_clr = 1'b1; step(); overrun_clr = 1'b0;
    chk("t5_overrun_cleared", overrun, 0);
    r.re = OW'(2); r.im = '0;
    exp_q.push_back(r);
    res_ready = 1'b1; step();
    chk("t5_res_valid_drop", res_valid, 0);
    chk("t5_sb_empty", exp_q.size(), 0);

    // stop during sample 2 of a len=4 continuous window
    cfg_len = LW'(4); cfg_continuous = 1'b1;
    r.re = OW'(148); r.im = OW'(-12);
    exp_q.push_back(r);
    start = 1'b1; step(); start = 1'b0;
    drive(mk(1, 5, 1, 7, -2), 1'b0);
    drive(mk(1, 5, 1, 7, -2), 1'b1);
    for (int i = 0; i < 4; i++) drive(mk(1, 5, 1, 7, -2), 1'b0);
    s_valid = 1'b0;
    finish_run("t6_stop");

    // reset in the middle of a window abandons it
    start = 1'b1; step(); start = 1'b0;
    drive(mk(1, 11, 0, 3, 0), 1'b0);
    drive(mk(1, 11, 0, 3, 0), 1'b0);
    s_valid = 1'b0;
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step();
    chk("t6_busy", busy, 0);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_res_re", res_re, 0);
    chk("t6_res_im", res_im, 0);
    chk("t6_overrun", overrun, 0);
    chk("t6_sload", mix_sload, 0);
    chk("t6_mix_ar", mix_ar, 0);

    // randomized windows, operands and gaps
    for (int it = 0; it < 8; it++) begin
      len  = $urandom_range(1, 5);
      nwin = $urandom_range(1, 3);
      stim.delete();
      vc = 0;
      while (vc < nwin * len + 3) begin
        vv = ($urandom_range(0, 9) < 7);
        stim.push_back(mk(vv, int'($urandom_range(0, 65535)) - 32768,
                          int'($urandom_range(0, 65535)) - 32768,
                          int'($urandom_range(0, 262143)) - 131072,
                          int'($urandom_range(0, 262143)) - 131072));
        if (vv) vc++;
      end
      play(len, (len == 1 && it[0]) ? 0 : len, nwin, it[1], 1);
      finish_run("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
